// File: rtl/l1_direct_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache between a word-wide core port and a
// 256-bit line-burst memory port. One request is outstanding at a time; a miss stalls the
// core until the writeback and fill complete.
// Optional feature: define L1_CACHE_PERF_EN to build the hit/miss performance counters;
// without it hit_count and miss_count are tied to zero.
module l1_direct_cache #(
  parameter int unsigned SETS      = 8,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {StIdle, StResp, StWriteback, StFill} state_e;

  state_e state_q, state_d;

  // Line storage; data and tags need no reset because valid gates their use.
  logic [LINE_BITS-1:0] data_q  [SETS];
  logic [TAG_W-1:0]     tag_q   [SETS];
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;

  // Request address captured on acceptance so a miss never re-reads the core port.
  logic [31:0] req_addr_q;

  // Live request decode (used in IDLE only).
  logic             req;
  logic             is_write;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             hit;
  logic [LINE_BITS-1:0] line_merged;

  // Captured request decode (used in RESP, WRITEBACK and FILL).
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       req_word;

  // Byte-select bits of the address carry no meaning for a word port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  assign req      = mem_read | mem_write;
  // Simultaneous read and write is illegal and resolved as a write.
  assign is_write = mem_write;
  assign idx      = mem_address[5+IDX_W-1:5];
  assign tag      = mem_address[31:5+IDX_W];
  assign word     = mem_address[4:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  assign req_idx  = req_addr_q[5+IDX_W-1:5];
  assign req_tag  = req_addr_q[31:5+IDX_W];
  assign req_word = req_addr_q[4:2];

  // Merge the enabled write bytes into the addressed word of the indexed line.
  always_comb begin
    line_merged = data_q[idx];
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        line_merged[32*int'(word) + 8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Next-state logic for the controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            state_d = StResp;
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = StWriteback;
          end else begin
            state_d = StFill;
          end
        end
      end
      StResp:      state_d = StIdle;
      StWriteback: if (pmem_resp) state_d = StFill;
      StFill:      if (pmem_resp) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // State register; reset aborts any miss in flight so strobes drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request address whenever the controller is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= '0;
    end else if (state_q == StIdle && req) begin
      req_addr_q <= mem_address;
    end
  end

  // Valid/dirty bookkeeping: fills install clean lines, write hits mark dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (state_q == StFill && pmem_resp) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end else if (state_q == StIdle && req && hit && is_write) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Line data and tag updates from write hits and completed fills.
  always_ff @(posedge clk) begin
    if (state_q == StFill && pmem_resp) begin
      data_q[req_idx] <= pmem_rdata;
      tag_q[req_idx]  <= req_tag;
    end else if (state_q == StIdle && req && hit && is_write) begin
      data_q[idx] <= line_merged;
    end
  end

  // Outputs decoded from state; everything reads zero while idle.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      StResp: begin
        mem_resp  = 1'b1;
        mem_rdata = data_q[req_idx][32*int'(req_word) +: 32];
      end
      StWriteback: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx], req_idx, 5'b0};
        pmem_wdata   = data_q[req_idx];
      end
      StFill: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, 5'b0};
      end
      default: ;
    endcase
  end

`ifdef L1_CACHE_PERF_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;
  // Set while a miss is being serviced so the post-fill hit is not counted.
  logic        miss_seen_q;

  // Performance counters, updated on IDLE decisions only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      miss_seen_q  <= 1'b0;
    end else if (state_q == StIdle && req) begin
      if (hit) begin
        if (!miss_seen_q) begin
          hit_count_q <= hit_count_q + 32'd1;
        end
        miss_seen_q <= 1'b0;
      end else begin
        miss_count_q <= miss_count_q + 32'd1;
        miss_seen_q  <= 1'b1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_direct_cache.sv
// Self-checking bench for l1_direct_cache: a flat word-memory reference model predicts read
// data, response latency and line traffic; a scoreboard monitor checks every mem_resp and a
// memory responder checks every pmem request.
module tb_l1_direct_cache;

  localparam int unsigned SETS   = 8;
  localparam int unsigned LAT    = 3;   // cycles each pmem strobe stays high
  localparam int unsigned NRAND  = 300;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  l1_direct_cache #(.SETS(SETS), .LINE_BITS(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } resp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } pop_t;

  resp_t resp_q[$];
  pop_t  pmem_q[$];

  // Reference model: flat word memory plus which line each set holds.
  logic [31:0]  ref_mem  [int unsigned];
  logic [255:0] line_mem [int unsigned];
  bit           res_valid [SETS];
  bit           res_dirty [SETS];
  int unsigned  res_line  [SETS];
  int unsigned  m_hits;
  int unsigned  m_misses;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Initial backing-store content; word index 0x19 (byte 0x64) is pinned for the directed tests.
  function automatic logic [31:0] init_word(input int unsigned widx);
    if (widx == 32'h19) return 32'hDEAD_BEEF;
    return (widx * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned widx);
    if (ref_mem.exists(widx)) return ref_mem[widx];
    return init_word(widx);
  endfunction

  function automatic logic [255:0] ref_line(input int unsigned line);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_word(line*8 + w);
    return l;
  endfunction

  function automatic logic [255:0] store_line(input int unsigned line);
    logic [255:0] l;
    if (line_mem.exists(line)) return line_mem[line];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(line*8 + w);
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      res_valid[s] = 0;
      res_dirty[s] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Apply one access to the model; returns the word the core should see and the latency.
  task automatic model_op(input logic [31:0] addr, input bit wr, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] data,
                          output int unsigned lat);
    int unsigned line = addr >> 5;
    int unsigned set  = line % SETS;
    int unsigned widx = addr >> 2;
    logic [31:0] w;
    pop_t op;
    if (res_valid[set] && res_line[set] == line) begin
      m_hits++;
      lat = 1;
    end else begin
      m_misses++;
      lat = LAT + 2;
      if (res_valid[set] && res_dirty[set]) begin
        op.wr = 1; op.addr = res_line[set] << 5; op.data = ref_line(res_line[set]);
        pmem_q.push_back(op);
        lat += LAT;
      end
      op.wr = 0; op.addr = line << 5; op.data = '0;
      pmem_q.push_back(op);
      res_valid[set] = 1;
      res_dirty[set] = 0;
      res_line[set]  = line;
    end
    if (wr) begin
      w = ref_word(widx);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[widx]  = w;
      res_dirty[set] = 1;
    end
    data = ref_word(widx);
  endtask

  // Issue one core request, push its expectation and hold it until mem_resp.
  task automatic issue(input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [3:0] be, input logic [31:0] wdata);
    logic [31:0] d;
    int unsigned lat;
    int n = 0;
    resp_t r;
    @(posedge clk); #1;
    model_op(addr, wr, be, wdata, d, lat);
    r.data = d;
    r.due  = cyc + lat;
    resp_q.push_back(r);
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wdata;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp && n < 200);
    checks++;
    if (!mem_resp) begin
      errors++;
      $display("FAIL resp_timeout: no mem_resp for addr %0h within 200 cycles", addr);
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
  endtask

  // Scoreboard monitor: every mem_resp must match the oldest expectation.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got rdata %0h expected no response", mem_rdata);
        end else begin
          r = resp_q.pop_front();
          chk("resp_rdata", mem_rdata, r.data);
          chk("resp_cycle", cyc, r.due);
        end
      end
    end
  end

  // Memory responder: checks each strobe against the model and answers after LAT cycles.
  initial begin
    pop_t e;
    int unsigned line;
    pmem_resp  = 0;
    pmem_rdata = '0;
    forever begin
      if (!(pmem_read || pmem_write)) begin
        @(negedge clk);
      end else begin
        chk("pmem_exclusive", {pmem_read, pmem_write} == 2'b11, 1'b0);
        line = pmem_address >> 5;
        if (pmem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pmem: got addr %0h expected no request", pmem_address);
        end else begin
          e = pmem_q.pop_front();
          chk("pmem_op_is_write", pmem_write, e.wr);
          chk("pmem_address", pmem_address, e.addr);
          if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
        end
        if (pmem_write) line_mem[line] = pmem_wdata;
        repeat (LAT - 1) @(negedge clk);
        pmem_rdata = store_line(line);
        pmem_resp  = 1;
        @(negedge clk);
        pmem_resp  = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk_counters(input string name);
    logic [31:0] eh, em;
`ifdef L1_CACHE_PERF_EN
    eh = m_hits; em = m_misses;
`else
    eh = 0; em = 0;
`endif
    chk({name, "_hit_count"}, hit_count, eh);
    chk({name, "_miss_count"}, miss_count, em);
  endtask

  initial begin
    logic [23:0] tags [4];
    logic [31:0] a;
    int unsigned kind;
    int n;
    pop_t op;

    rst_n = 0; mem_read = 0; mem_write = 0;
    mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_mem_resp", mem_resp, 1'b0);
    chk("reset_mem_rdata", mem_rdata, 32'h0);
    chk("reset_pmem_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("reset_pmem_address", pmem_address, 32'h0);
    chk("reset_pmem_wdata", pmem_wdata, 256'h0);
    chk_counters("reset");

    // Directed: cold miss, hit, write hit, readback, dirty eviction.
    issue(32'h0000_0060, 1, 0, 4'h0, 32'h0);
    issue(32'h0000_0064, 1, 0, 4'h0, 32'h0);
    issue(32'h0000_0064, 0, 1, 4'b0011, 32'h1234_5678);
    issue(32'h0000_0064, 1, 0, 4'h0, 32'h0);
    chk("merged_word", ref_word(32'h19), 32'hDEAD_5678);
    issue(32'h0000_0160, 1, 0, 4'h0, 32'h0);
    chk_counters("after_directed");

    // Reset in the middle of a fill: strobe drops immediately, line stays invalid.
    @(posedge clk); #1;
    op.wr = 0; op.addr = 32'h0000_0260; op.data = '0;
    pmem_q.push_back(op);
    mem_address = 32'h0000_0260; mem_read = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_read && n < 50);
    chk("fill_started", pmem_read, 1'b1);
    #1 rst_n = 0;
    #1;
    chk("reset_drops_pmem_read", pmem_read, 1'b0);
    chk("reset_drops_pmem_address", pmem_address, 32'h0);
    mem_read = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    repeat (6) @(posedge clk);
    chk_counters("after_mid_fill_reset");
    issue(32'h0000_0160, 1, 0, 4'h0, 32'h0);

    // Randomized traffic over four tags to force hits, conflicts and dirty evictions.
    for (int t = 0; t < 4; t++) tags[t] = 24'($urandom);
    for (int i = 0; i < NRAND; i++) begin
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, SETS - 1)), 5'($urandom)};
      kind = $urandom_range(0, 19);
      if (kind < 10)       issue(a, 1, 0, 4'($urandom), $urandom);
      else if (kind < 19)  issue(a, 0, 1, 4'($urandom), $urandom);
      else                 issue(a, 1, 1, 4'($urandom), $urandom);
    end

    repeat (5) @(posedge clk);
    chk_counters("final");
    chk("scoreboard_drained", resp_q.size(), 0);
    chk("pmem_queue_drained", pmem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
